// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg
// Shared definitions for the iterative divider slice: the sequencer state
// encoding and the symbolic values used for the ready flag and the start
// request.
package div_ctrl_pkg;

  // Sequencer states, encoded in two bits.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } divState_e;

  // Result-valid flag values.
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Start request values as driven by EX.
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

endpackage : div_ctrl_pkg

// File: rtl/div_ctrl_step.sv
// div_step
// One combinational radix-2 restoring divide step.
// Ports:
//   i_rem      partial remainder from the previous step
//   i_dvdMsb   next dividend bit shifted into the remainder
//   i_divisor  divisor magnitude
//   o_rem      partial remainder for the next step
//   o_qBit     quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvdMsb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qBit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  // The shifted remainder can need WIDTH+1 bits when the divisor has its MSB
  // set, so the trial subtraction is done one bit wider; a set top bit of the
  // difference means the divisor did not fit and the remainder is restored.
  // Because the remainder is always below the divisor, whichever value is
  // kept fits back into WIDTH bits.
  always_comb begin
    w_shifted = {i_rem, i_dvdMsb};
    w_trial   = w_shifted - {1'b0, i_divisor};
    o_qBit    = ~w_trial[WIDTH];
    o_rem     = o_qBit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  end

endmodule : div_step

// File: rtl/div_ctrl.sv
// div_ctrl
// Iterative 32-bit divider and sequencer for the EX stage. A DIV/DIVU request
// is latched, run through WIDTH restoring steps (one per cycle) and the sign-
// corrected {remainder, quotient} is presented until EX drops the request.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start_i      divide request, held until the result is consumed
//   signed_i     1 = signed DIV, 0 = unsigned DIVU
//   annul_i      flush/exception cancel, aborts any operation
//   opdata1_i    dividend
//   opdata2_i    divisor
//   result_o     {remainder, quotient}, valid while ready_o is high
//   ready_o      result valid
//   stallreq_o   combinational pipeline stall request
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  divState_e          r_state;
  divState_e          w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_signQ;
  logic               r_signR;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic               w_divByZero;
  logic               w_lastIter;
  logic               w_dvdNeg;
  logic               w_dvsNeg;
  logic [WIDTH-1:0]   w_dvdAbs;
  logic [WIDTH-1:0]   w_dvsAbs;
  logic [WIDTH-1:0]   w_stepRem;
  logic               w_qBit;
  logic [WIDTH-1:0]   w_quoFinal;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_dvdMsb (r_dvd[WIDTH-1]),
    .i_divisor(r_dvs),
    .o_rem    (w_stepRem),
    .o_qBit   (w_qBit)
  );

  // Operand magnitudes and the final sign fix-up. The dividend register
  // doubles as the quotient shift register, so on the last step the quotient
  // is the shifted register plus the bit being produced. The most negative
  // dividend's magnitude is its own bit pattern, which makes MIN / -1 wrap
  // to MIN without any special case.
  always_comb begin
    w_divByZero = (opdata2_i == '0);
    w_lastIter  = (r_cnt == CNT_W'(WIDTH - 1));
    w_dvdNeg    = signed_i & opdata1_i[WIDTH-1];
    w_dvsNeg    = signed_i & opdata2_i[WIDTH-1];
    w_dvdAbs    = w_dvdNeg ? -opdata1_i : opdata1_i;
    w_dvsAbs    = w_dvsNeg ? -opdata2_i : opdata2_i;
    w_quoFinal  = {r_dvd[WIDTH-2:0], w_qBit};
    w_quoFix    = r_signQ ? -w_quoFinal : w_quoFinal;
    w_remFix    = r_signR ? -w_stepRem : w_stepRem;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DivFree;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; a cancel returns to idle from anywhere.
  always_comb begin
    w_nextState = r_state;
    if (annul_i) begin
      w_nextState = DivFree;
    end else begin
      case (r_state)
        DivFree: begin
          if (start_i == DivStart) begin
            w_nextState = w_divByZero ? DivByZero : DivOn;
          end
        end
        DivByZero: w_nextState = DivEnd;
        DivOn: begin
          if (w_lastIter) begin
            w_nextState = DivEnd;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            w_nextState = DivFree;
          end
        end
      endcase
    end
  end

  // Stall while a request is being accepted or worked on. Reset and cancel
  // both suppress it in the same cycle so the pipeline is released at once.
  always_comb begin
    stallreq_o = 1'b0;
    if (!rst && !annul_i) begin
      case (r_state)
        DivFree:   stallreq_o = (start_i == DivStart);
        DivByZero: stallreq_o = 1'b1;
        DivOn:     stallreq_o = 1'b1;
        DivEnd:    stallreq_o = 1'b0;
      endcase
    end
  end

  // Datapath: operand latch, iteration, result capture and release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_signQ  <= 1'b0;
      r_signR  <= 1'b0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else if (annul_i) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          r_result <= '0;
          r_ready  <= DivResultNotReady;
          if (start_i == DivStart) begin
            r_dvd   <= w_dvdAbs;
            r_dvs   <= w_dvsAbs;
            r_signQ <= w_dvdNeg ^ w_dvsNeg;
            r_signR <= w_dvdNeg;
            r_rem   <= '0;
            r_cnt   <= '0;
          end
        end
        DivByZero: begin
          r_result <= '0;
          r_ready  <= DivResultReady;
        end
        DivOn: begin
          r_rem <= w_stepRem;
          r_dvd <= w_quoFinal;
          r_cnt <= r_cnt + 1'b1;
          if (w_lastIter) begin
            r_result <= {w_remFix, w_quoFix};
            r_ready  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            r_result <= '0;
            r_ready  <= DivResultNotReady;
          end
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule : div_ctrl

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl
// Self-checking bench for div_ctrl: a table of directed divides with hand-
// computed results and latencies, plus hand-written cancel and reset
// sequences. Inputs change on the falling edge; outputs are sampled 1 time
// unit later, well away from the rising edge.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       name;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        sgn;
    logic [63:0] expResult;
    int          expCycle;
  } vec_t;

  vec_t vecs[10];

  div_ctrl #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .annul_i   (annul_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Run one divide: raise start in cycle 0, scramble the operands after they
  // are latched, expect stall high and ready low until the expected cycle,
  // then check the result, hold one extra cycle in END and release.
  task automatic applyStimulus(input vec_t v);
    logic stallOk = 1'b1;
    logic earlyReady = 1'b0;
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = v.sgn;
    opdata1_i = v.dvd;
    opdata2_i = v.dvs;
    for (int cyc = 0; cyc < v.expCycle; cyc++) begin
      #1;
      if (stallreq_o !== 1'b1) stallOk = 1'b0;
      if (ready_o !== 1'b0) earlyReady = 1'b1;
      if (cyc == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~v.sgn;
      end
      @(negedge clk);
    end
    #1;
    checkOutput({v.name, " stall while busy"}, 64'(stallOk), 64'd1);
    checkOutput({v.name, " no early ready"}, 64'(earlyReady), 64'd0);
    checkOutput({v.name, " ready"}, 64'(ready_o), 64'd1);
    checkOutput({v.name, " stall at end"}, 64'(stallreq_o), 64'd0);
    checkOutput({v.name, " result"}, result_o, v.expResult);
    @(negedge clk);
    #1;
    checkOutput({v.name, " result held"}, result_o, v.expResult);
    start_i = 1'b0;
    @(negedge clk);
    #1;
    checkOutput({v.name, " ready drop"}, 64'(ready_o), 64'd0);
    checkOutput({v.name, " result clear"}, result_o, 64'd0);
    checkOutput({v.name, " idle stall"}, 64'(stallreq_o), 64'd0);
  endtask

  initial begin
    vecs[0] = '{"u 100/7",           32'd100,        32'd7,          1'b0, {32'd2,          32'd14},         33};
    vecs[1] = '{"s -7/2",            32'hFFFFFFF9,   32'd2,          1'b1, {32'hFFFFFFFF,   32'hFFFFFFFD},   33};
    vecs[2] = '{"u FFFFFFFF/16",     32'hFFFFFFFF,   32'd16,         1'b0, {32'd15,         32'h0FFFFFFF},   33};
    vecs[3] = '{"u 5/0",             32'd5,          32'd0,          1'b0, 64'd0,                            2};
    vecs[4] = '{"s MIN/-1",          32'h80000000,   32'hFFFFFFFF,   1'b1, {32'd0,          32'h80000000},   33};
    vecs[5] = '{"u big divisor",     32'hFFFFFFFF,   32'h80000001,   1'b0, {32'h7FFFFFFE,   32'd1},          33};
    vecs[6] = '{"s 7/-2",            32'd7,          32'hFFFFFFFE,   1'b1, {32'd1,          32'hFFFFFFFD},   33};
    vecs[7] = '{"s -100/-7",         32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, {32'hFFFFFFFE,   32'd14},         33};
    vecs[8] = '{"s 5/0",             32'd5,          32'd0,          1'b1, 64'd0,                            2};
    vecs[9] = '{"u 80000000/FFFFFFFF", 32'h80000000, 32'hFFFFFFFF,   1'b0, {32'h80000000,   32'd0},          33};

    // Reset with a request pending: the request must be ignored.
    rst       = 1'b1;
    start_i   = 1'b1;
    signed_i  = 1'b0;
    annul_i   = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset stall", 64'(stallreq_o), 64'd0);
    checkOutput("reset ready", 64'(ready_o), 64'd0);
    checkOutput("reset result", result_o, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("post-reset idle stall", 64'(stallreq_o), 64'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
    end

    // Cancel at cycle 10, idle at cycle 11, fresh request at cycle 12.
    begin
      logic readySeen = 1'b0;
      @(negedge clk);
      start_i   = 1'b1;
      signed_i  = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      for (int cyc = 0; cyc < 10; cyc++) begin
        #1;
        if (ready_o !== 1'b0) readySeen = 1'b1;
        @(negedge clk);
      end
      annul_i = 1'b1;
      #1;
      checkOutput("annul stall same cycle", 64'(stallreq_o), 64'd0);
      checkOutput("annul no ready before", 64'(readySeen), 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      #1;
      checkOutput("annul idle stall", 64'(stallreq_o), 64'd0);
      checkOutput("annul idle ready", 64'(ready_o), 64'd0);
      checkOutput("annul idle result", result_o, 64'd0);
      applyStimulus(vecs[0]);
    end

    // Reset at cycle 15 of a running divide, then recover.
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = 1'b1;
    opdata1_i = 32'hFFFFFFF9;
    opdata2_i = 32'd2;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid reset stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("after reset stall", 64'(stallreq_o), 64'd0);
    checkOutput("after reset ready", 64'(ready_o), 64'd0);
    checkOutput("after reset result", result_o, 64'd0);
    applyStimulus(vecs[1]);
    applyStimulus(vecs[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_div_ctrl
